i2c_addr_sequencer: RTL and testbench
=====================================

Name: i2c_addr_sequencer

Overview:
Parametrised register-address sequencer for the I2C EEPROM master. It tracks the master FSM state and supplies the multi-byte register address, MSB first, during the address phase. During data phases it auto-increments the current address, with either EEPROM page-wrap or linear wrap. It also counts the burst length and flags burst completion, and keeps the random-read "setting done" flag used for the repeated start.

Parameters:
ADDR_W, 16, register address width in bits (8..32); ADDR_BYTES = ceil(ADDR_W/8)
PAGE_BITS, 5, page size = 2^PAGE_BITS bytes (1..ADDR_W); used when i_Wrap_Mode=1
LEN_W, 8, burst length counter width

Ports:
i_clk10MHz  in  1  system clock
i_RST_n  in  1  reset, synchronous, active-low
i_Current_State  in  3  master FSM state (shared encoding)
i_Start_Addr  in  ADDR_W  first register address of the transfer
i_Burst_Len  in  LEN_W  number of data bytes; sampled in Start
i_Wrap_Mode  in  1  1 = page wrap (writes); 0 = linear full-range wrap (reads)
i_Byte_Done  in  1  one-cycle pulse at the ACK slot of each address or data byte
o_Current_Addr  out  ADDR_W  address of the byte currently being transferred
o_Addr_Byte  out  8  address byte to shift out in Reg_Addr_Send (combinational)
o_Addr_Byte_Last  out  1  o_Addr_Byte is the final address byte
o_Read_Setting_Flag  out  1  Read_Setting_Done (1) / Read_Setting_NotDone (0)
o_Remaining  out  LEN_W  data bytes still to transfer
o_Burst_Done  out  1  all requested bytes transferred
o_Page_Wrap  out  1  one-cycle pulse when an increment wrapped

Behaviour:
- All registers update on the rising edge of i_clk10MHz. When i_RST_n=0 at an edge, all registers clear: o_Current_Addr=0, flag=NotDone, o_Remaining=0, o_Burst_Done=0, o_Page_Wrap=0, byte index=0. There is no asynchronous path.
- A mid-operation reset takes effect on the next edge regardless of state.
- Idle: address held; flag=NotDone; index=0; o_Burst_Done=0.
- Start:
  - flag <= (o_Current_Addr==i_Start_Addr[ADDR_W-1:0]) ? Done : NotDone.
  - o_Remaining <= i_Burst_Len; o_Burst_Done <= 0; index <= 0.
- Chip_Addr_Send: all registers hold.
- Reg_Addr_Send:
  - o_Current_Addr <= i_Start_Addr every cycle; flag <= Done.
  - o_Addr_Byte = byte (ADDR_BYTES-1-index) of i_Start_Addr, zero-padded above ADDR_W.
  - On i_Byte_Done, index increments, saturating at ADDR_BYTES-1.
  - o_Addr_Byte_Last = (index==ADDR_BYTES-1).
- Data_Send / Data_Rcv, on i_Byte_Done with o_Remaining>0:
  - o_Remaining decrements.
  - Page mode: address bits [PAGE_BITS-1:0] increment modulo 2^PAGE_BITS; upper bits hold.
  - Linear mode: the full address increments modulo 2^ADDR_W.
  - o_Page_Wrap pulses for exactly one cycle (same edge as the address update) when the incremented field wraps from all-ones to zero.
  - o_Burst_Done <= 1 when o_Remaining goes 1->0.
  - A 1-cycle gap between consecutive i_Byte_Done pulses is legal.
- Data_Send / Data_Rcv, when o_Remaining==0:
  - o_Burst_Done is 1, including the i_Burst_Len=0 case, from the first data-state cycle.
  - i_Byte_Done is ignored; the address holds.
- Flag holds in data states. o_Burst_Done holds until the next Start or Idle.
- Stop and any undefined state code: address and counters hold; flag <= NotDone.
- o_Page_Wrap defaults to 0 on every cycle without a wrap.
- Latency: one cycle from i_Byte_Done to updated o_Current_Addr, o_Remaining and o_Burst_Done. o_Addr_Byte follows index with zero extra latency.

Decomposition:
- Shared include i2c_defines.vh holds:
  - state codes: Idle=0, Start=1, Chip_Addr_Send=2, Reg_Addr_Send=3, Data_Send=4, Data_Rcv=5, Stop=6;
  - Read_Setting_Done=1, Read_Setting_NotDone=0.
  - It is shared with the master FSM.
- One sub-module, i2c_addr_incr: combinational next-address and wrap-detect logic, parametrised by ADDR_W and PAGE_BITS, with a wrap-mode input.

Test Plan:
- Reset: drive i_RST_n=0 for 2 edges in Data_Send with address 0x0023 -> after the edge, all registered outputs are 0. Pulsing i_RST_n low between edges has no effect.
- Address phase: i_Start_Addr=0x12A4, state Reg_Addr_Send -> o_Addr_Byte=0x12, Last=0. After an i_Byte_Done pulse -> 0x12 becomes 0xA4, Last=1, o_Current_Addr=0x12A4, flag=1.
- Page-wrap write: start 0x003E, len 4, i_Wrap_Mode=1, four i_Byte_Done in Data_Send:
  - addresses 0x003F, 0x0020, 0x0021, 0x0022;
  - o_Page_Wrap pulses only on the second update;
  - o_Remaining 3,2,1,0; o_Burst_Done=1 after the fourth.
  - A fifth pulse leaves the address at 0x0022.
- Linear read wrap: start 0xFFFF, len 2, i_Wrap_Mode=0, Data_Rcv -> 0x0000 (o_Page_Wrap pulse), then 0x0001, then o_Burst_Done=1.
- Zero length: i_Burst_Len=0 -> o_Burst_Done=1 on the first Data_Send cycle; i_Byte_Done leaves the address unchanged.
- Repeated start: after Reg_Addr_Send with 0x0050, return to Start with i_Start_Addr=0x0050 -> flag=1. With i_Start_Addr=0x0051 -> flag=0. Idle -> flag=0.

Source files
------------

// File: rtl/i2c_addr_sequencer_pkg.sv
// Shared I2C master definitions: state codes, read-setting flag values, helpers.
package i2c_addr_sequencer_pkg;

  // Master FSM state encoding, shared with the I2C master FSM.
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_START          = 3'd1,
    ST_CHIP_ADDR_SEND = 3'd2,
    ST_REG_ADDR_SEND  = 3'd3,
    ST_DATA_SEND      = 3'd4,
    ST_DATA_RCV       = 3'd5,
    ST_STOP           = 3'd6
  } i2c_state_e;

  // Random-read setting flag values used to decide on a repeated start.
  localparam logic READ_SETTING_DONE    = 1'b1;
  localparam logic READ_SETTING_NOTDONE = 1'b0;

  // Default widths.
  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_PAGE_BITS = 5;
  localparam int unsigned DEF_LEN_W     = 8;

  // Number of bytes needed to carry an address of the given width.
  function automatic int unsigned addr_bytes(input int unsigned addr_w);
    return (addr_w + 32'd7) / 32'd8;
  endfunction

  // Width of a byte index over addr_bytes(addr_w) bytes (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned addr_w);
    return (addr_bytes(addr_w) > 32'd1) ? $clog2(addr_bytes(addr_w)) : 32'd1;
  endfunction

endpackage

// File: rtl/i2c_addr_incr.sv
// Next-address and wrap detection for data-phase auto-increment.
module i2c_addr_incr
  import i2c_addr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned PAGE_BITS = DEF_PAGE_BITS
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wrap_mode,
  output logic [ADDR_W-1:0] o_next_addr_c,
  output logic              o_wrap_c
);

  // Mask of the in-page offset bits; all ones when the page spans the full address.
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_BITS) - 64'd1);

  logic [ADDR_W-1:0] w_plus1;

  assign w_plus1 = i_addr + ADDR_W'(1);

  // Page mode keeps the page bits and wraps the offset; linear mode wraps the full range.
  always_comb begin
    o_next_addr_c = w_plus1;
    o_wrap_c      = &i_addr;
    if (i_wrap_mode) begin
      o_next_addr_c = (i_addr & ~PAGE_MASK) | (w_plus1 & PAGE_MASK);
      o_wrap_c      = ((i_addr & PAGE_MASK) == PAGE_MASK);
    end
  end

endmodule

// File: rtl/i2c_addr_sequencer.sv
// Register-address sequencer for the I2C EEPROM master: address phase byte
// selection, data-phase auto-increment, burst counting and read-setting flag.
module i2c_addr_sequencer
  import i2c_addr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned PAGE_BITS = DEF_PAGE_BITS,
  parameter int unsigned LEN_W     = DEF_LEN_W
) (
  input  logic              i_clk10MHz,
  input  logic              i_RST_n,
  input  logic [2:0]        i_Current_State,
  input  logic [ADDR_W-1:0] i_Start_Addr,
  input  logic [LEN_W-1:0]  i_Burst_Len,
  input  logic              i_Wrap_Mode,
  input  logic              i_Byte_Done,
  output logic [ADDR_W-1:0] o_Current_Addr,
  output logic [7:0]        o_Addr_Byte,
  output logic              o_Addr_Byte_Last,
  output logic              o_Read_Setting_Flag,
  output logic [LEN_W-1:0]  o_Remaining,
  output logic              o_Burst_Done,
  output logic              o_Page_Wrap
);

  localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_W);
  localparam int unsigned IDX_W      = idx_width(ADDR_W);
  localparam int unsigned PAD_W      = ADDR_BYTES * 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADDR_BYTES - 1);

  // Registered state.
  logic [ADDR_W-1:0] r_addr;
  logic              r_flag;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_burst_done;
  logic              r_page_wrap;
  logic [IDX_W-1:0]  r_idx;
  logic              r_armed;

  // Next-state values.
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_flag_nxt;
  logic [LEN_W-1:0]  w_remaining_nxt;
  logic              w_burst_done_nxt;
  logic              w_page_wrap_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_armed_nxt;

  // Helper wires.
  logic [ADDR_W-1:0] w_incr_addr;
  logic              w_incr_wrap;
  logic              w_in_data;
  logic [PAD_W-1:0]  w_addr_pad;
  logic [IDX_W-1:0]  w_byte_sel;

  i2c_addr_incr #(
    .ADDR_W    (ADDR_W),
    .PAGE_BITS (PAGE_BITS)
  ) u_addr_incr (
    .i_addr        (r_addr),
    .i_wrap_mode   (i_Wrap_Mode),
    .o_next_addr_c (w_incr_addr),
    .o_wrap_c      (w_incr_wrap)
  );

  assign w_in_data = (i_Current_State == ST_DATA_SEND) ||
                     (i_Current_State == ST_DATA_RCV);

  // Next-state logic for all sequencer registers, keyed on the master state.
  always_comb begin
    w_addr_nxt       = r_addr;
    w_flag_nxt       = r_flag;
    w_remaining_nxt  = r_remaining;
    w_burst_done_nxt = r_burst_done;
    w_page_wrap_nxt  = 1'b0;
    w_idx_nxt        = r_idx;
    w_armed_nxt      = r_armed;
    case (i_Current_State)
      ST_IDLE: begin
        w_flag_nxt       = READ_SETTING_NOTDONE;
        w_idx_nxt        = '0;
        w_burst_done_nxt = 1'b0;
        w_armed_nxt      = 1'b0;
      end
      ST_START: begin
        w_flag_nxt       = (r_addr == i_Start_Addr) ? READ_SETTING_DONE
                                                    : READ_SETTING_NOTDONE;
        w_remaining_nxt  = i_Burst_Len;
        w_burst_done_nxt = 1'b0;
        w_idx_nxt        = '0;
        w_armed_nxt      = 1'b1;
      end
      ST_CHIP_ADDR_SEND: begin
      end
      ST_REG_ADDR_SEND: begin
        w_addr_nxt = i_Start_Addr;
        w_flag_nxt = READ_SETTING_DONE;
        if (i_Byte_Done && (r_idx != IDX_LAST)) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      ST_DATA_SEND, ST_DATA_RCV: begin
        if (r_remaining == '0) begin
          w_burst_done_nxt = 1'b1;
        end else if (i_Byte_Done) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          w_addr_nxt      = w_incr_addr;
          w_page_wrap_nxt = w_incr_wrap;
          if (r_remaining == LEN_W'(1)) begin
            w_burst_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_flag_nxt = READ_SETTING_NOTDONE;
      end
    endcase
  end

  // Synchronous active-low reset; all state clears on the edge.
  always_ff @(posedge i_clk10MHz) begin
    if (!i_RST_n) begin
      r_addr       <= '0;
      r_flag       <= READ_SETTING_NOTDONE;
      r_remaining  <= '0;
      r_burst_done <= 1'b0;
      r_page_wrap  <= 1'b0;
      r_idx        <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_flag       <= w_flag_nxt;
      r_remaining  <= w_remaining_nxt;
      r_burst_done <= w_burst_done_nxt;
      r_page_wrap  <= w_page_wrap_nxt;
      r_idx        <= w_idx_nxt;
      r_armed      <= w_armed_nxt;
    end
  end

  assign w_addr_pad = PAD_W'(i_Start_Addr);
  assign w_byte_sel = IDX_LAST - r_idx;

  // Address byte to shift out, MSB byte first; follows the index with no delay.
  always_comb begin
    o_Addr_Byte = '0;
    for (int unsigned b = 0; b < ADDR_BYTES; b++) begin
      if (w_byte_sel == IDX_W'(b)) begin
        o_Addr_Byte = w_addr_pad[b*8 +: 8];
      end
    end
  end

  assign o_Addr_Byte_Last    = (r_idx == IDX_LAST);
  assign o_Current_Addr      = r_addr;
  assign o_Read_Setting_Flag = r_flag;
  assign o_Remaining         = r_remaining;
  assign o_Page_Wrap         = r_page_wrap;

  // A zero-length burst must read as done on the very first data cycle, before
  // the latched bit can update; r_armed keeps that term quiet until a Start.
  assign o_Burst_Done = r_burst_done |
                        (w_in_data & r_armed & (r_remaining == '0));

endmodule

// File: tb/tb_i2c_addr_sequencer.sv
// Self-checking bench for i2c_addr_sequencer: directed scenarios plus random
// state/strobe traffic compared against a behavioural model.
module tb_i2c_addr_sequencer;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned PAGE_BITS = 5;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned AB        = (ADDR_W + 7) / 8;
  localparam int unsigned PAGE      = 1 << PAGE_BITS;
  localparam int unsigned ASPAN     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        state;
  logic [ADDR_W-1:0] start;
  logic [LEN_W-1:0]  len;
  logic              wrap;
  logic              bd;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        abyte;
  logic              alast;
  logic              flag;
  logic [LEN_W-1:0]  remaining;
  logic              bdone;
  logic              pwrap;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  int unsigned m_addr;
  int unsigned m_rem;
  int unsigned m_idx;
  bit          m_flag;
  bit          m_done;
  bit          m_wrap;
  bit          m_seen;

  i2c_addr_sequencer #(
    .ADDR_W    (ADDR_W),
    .PAGE_BITS (PAGE_BITS),
    .LEN_W     (LEN_W)
  ) dut (
    .i_clk10MHz          (clk),
    .i_RST_n             (rst_n),
    .i_Current_State     (state),
    .i_Start_Addr        (start),
    .i_Burst_Len         (len),
    .i_Wrap_Mode         (wrap),
    .i_Byte_Done         (bd),
    .o_Current_Addr      (cur_addr),
    .o_Addr_Byte         (abyte),
    .o_Addr_Byte_Last    (alast),
    .o_Read_Setting_Flag (flag),
    .o_Remaining         (remaining),
    .o_Burst_Done        (bdone),
    .o_Page_Wrap         (pwrap)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned advance(input int unsigned a, input bit page_mode,
                                          output bit wrapped);
    int unsigned off;
    int unsigned n;
    if (page_mode) begin
      off     = ((a % PAGE) + 1) % PAGE;
      wrapped = (off == 0);
      return a - (a % PAGE) + off;
    end
    n       = (a + 1) % ASPAN;
    wrapped = (n == 0);
    return n;
  endfunction

  // Apply one clock edge of the spec's rules to the model.
  task automatic model_step();
    bit w;
    if (!rst_n) begin
      m_addr = 0; m_rem = 0; m_idx = 0;
      m_flag = 0; m_done = 0; m_wrap = 0; m_seen = 0;
      return;
    end
    m_wrap = 0;
    case (int'(state))
      0: begin m_flag = 0; m_idx = 0; m_done = 0; m_seen = 0; end
      1: begin
        m_flag = (m_addr == int'(start));
        m_rem  = int'(len);
        m_done = 0; m_idx = 0; m_seen = 1;
      end
      2: ;
      3: begin
        m_addr = int'(start);
        m_flag = 1;
        if (bd && m_idx < AB - 1) m_idx++;
      end
      4, 5: begin
        if (m_rem == 0) m_done = 1;
        else if (bd) begin
          m_rem--;
          m_addr = advance(m_addr, wrap, w);
          m_wrap = w;
          if (m_rem == 0) m_done = 1;
        end
      end
      default: m_flag = 0;
    endcase
  endtask

  task automatic check_all();
    bit          in_data;
    bit          exp_done;
    int unsigned exp_byte;
    in_data  = (state == 3'd4) || (state == 3'd5);
    exp_done = m_done || (in_data && m_rem == 0 && m_seen);
    exp_byte = (int'(start) >> (8 * (AB - 1 - m_idx))) & 32'hFF;
    check("addr",  32'(cur_addr),  m_addr);
    check("abyte", 32'(abyte),     exp_byte);
    check("alast", 32'(alast),     32'(m_idx == AB - 1));
    check("flag",  32'(flag),      32'(m_flag));
    check("rem",   32'(remaining), m_rem);
    check("done",  32'(bdone),     32'(exp_done));
    check("pwrap", 32'(pwrap),     32'(m_wrap));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic go(input logic [2:0] s, input logic b);
    state = s;
    bd    = b;
    tick();
  endtask

  initial begin
    logic [15:0] exp_pg [4];
    logic        exp_pw [4];
    exp_pg = '{16'h003F, 16'h0020, 16'h0021, 16'h0022};
    exp_pw = '{1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; state = 3'd4; start = 16'h0023; len = 8'd3; wrap = 1'b1; bd = 1'b1;
    m_addr = 0; m_rem = 0; m_idx = 0; m_flag = 0; m_done = 0; m_wrap = 0; m_seen = 0;
    @(negedge clk);

    // Reset held for two edges in Data_Send.
    tick();
    tick();
    check("rst_addr", 32'(cur_addr), 32'h0);
    check("rst_done", 32'(bdone), 32'h0);
    rst_n = 1'b1;
    go(3'd0, 1'b0);

    // Address phase.
    start = 16'h12A4;
    go(3'd3, 1'b0);
    check("aphase_b0", 32'(abyte), 32'h12);
    check("aphase_l0", 32'(alast), 32'h0);
    go(3'd3, 1'b1);
    check("aphase_b1", 32'(abyte), 32'hA4);
    check("aphase_l1", 32'(alast), 32'h1);
    check("aphase_ad", 32'(cur_addr), 32'h12A4);
    check("aphase_fl", 32'(flag), 32'h1);
    go(3'd3, 1'b1);

    // Page-wrap write burst with gaps between strobes.
    start = 16'h003E; len = 8'd4; wrap = 1'b1;
    go(3'd1, 1'b0);
    go(3'd2, 1'b0);
    go(3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      go(3'd4, 1'b1);
      check("pg_addr", 32'(cur_addr), 32'(exp_pg[i]));
      check("pg_wrap", 32'(pwrap), 32'(exp_pw[i]));
      check("pg_rem",  32'(remaining), 32'(3 - i));
      go(3'd4, 1'b0);
    end
    check("pg_done", 32'(bdone), 32'h1);
    go(3'd4, 1'b1);
    check("pg_hold", 32'(cur_addr), 32'h0022);
    go(3'd6, 1'b0);

    // Linear read wrap.
    start = 16'hFFFF; len = 8'd2; wrap = 1'b0;
    go(3'd1, 1'b0);
    go(3'd3, 1'b0);
    go(3'd5, 1'b1);
    check("lin_a0", 32'(cur_addr), 32'h0000);
    check("lin_w0", 32'(pwrap), 32'h1);
    go(3'd5, 1'b1);
    check("lin_a1", 32'(cur_addr), 32'h0001);
    check("lin_dn", 32'(bdone), 32'h1);
    go(3'd6, 1'b0);

    // Zero-length burst.
    start = 16'h0100; len = 8'd0; wrap = 1'b1;
    go(3'd1, 1'b0);
    go(3'd3, 1'b0);
    state = 3'd4; bd = 1'b1;
    #1;
    check("zl_first", 32'(bdone), 32'h1);
    tick();
    check("zl_addr", 32'(cur_addr), 32'h0100);
    go(3'd6, 1'b0);

    // Repeated start flag.
    start = 16'h0050; len = 8'd1;
    go(3'd1, 1'b0);
    go(3'd3, 1'b1);
    go(3'd1, 1'b0);
    check("rs_same", 32'(flag), 32'h1);
    start = 16'h0051;
    go(3'd1, 1'b0);
    check("rs_diff", 32'(flag), 32'h0);
    go(3'd0, 1'b0);
    check("rs_idle", 32'(flag), 32'h0);

    // Reset pulse between edges must be ignored.
    start = 16'h0200; len = 8'd3;
    go(3'd1, 1'b0);
    go(3'd3, 1'b0);
    state = 3'd4; bd = 1'b1;
    #10 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    tick();
    check("glitch", 32'(cur_addr), 32'h0201);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        start = 16'($urandom);
        if ($urandom_range(0, 1) == 1) start[4:0] = 5'h1C + 5'($urandom_range(0, 3));
        len   = 8'($urandom_range(0, 6));
        wrap  = 1'($urandom_range(0, 1));
      end
      bd = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
